picomips_core: RTL and testbench
================================

# picomips_core

Parametrised successor to the single-cycle picoMIPS CPU. It contains the program counter, decoder, a register file of configurable depth, an ALU with a signed fractional multiply, and a three-state run-control FSM. Input and output ports use valid/ready handshakes, replacing the free-running switch input and the unqualified output latch. The core sits between an external combinational program ROM and the board I/O (switches and LEDs, or a stream source and sink).

## Interface
Parameters:
- N, 8: data width.
- NREG, 8: number of general registers (power of 2, ≥2). r0 reads as 0 and ignores writes.
- PSIZE, 5: program address width (2^PSIZE instructions).
- RB, $clog2(NREG): register field width (derived, not overridden).
- ISIZE, 4+2*RB+N: instruction width (derived).

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins execution at address 0.
- paddr  out  PSIZE  program ROM address (equal to the PC).
- instr  in  ISIZE  instruction returned combinationally by the ROM for paddr.
- in_data  in  N  input operand.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  core is consuming in_data this cycle.
- out_data  out  N  registered output value.
- out_valid  out  1  out_data is pending.
- out_ready  in  1  sink accepts out_data.
- halted  out  1  FSM is in the HALT state.

## Operation
Instruction fields: op = instr[ISIZE-1 -: 4], rd = next RB bits, rs = next RB bits, imm = instr[N-1:0].

Opcodes:
- 0 NOP.
- 1 ADD: rd = rd + rs.
- 2 ADDI: rd = rd + imm.
- 3 SUB: rd = rd − rs.
- 4 SUBI: rd = rd − imm.
- 5 MULI: rd = P[2N-2:N-1], where P is the signed 2N-bit product rd*imm (Q1.(N-1) fractional multiply).
- 6 MOV: rd = rs.
- 7 LDI: rd = imm.
- 8 IN: rd = in_data.
- 9 OUT: out_data = rd.
- A BEQ: branch to imm[PSIZE-1:0] if Z=1.
- B BNE: branch to imm[PSIZE-1:0] if Z=0.
- C JMP: branch to imm[PSIZE-1:0].
- D HALT.
- E, F: reserved, executed as NOP.

Arithmetic and flags:
- All arithmetic is modulo 2^N.
- Flag Z is a register. It is updated only by ADD, ADDI, SUB, SUBI and MULI, and is set when the written result is 0. All other opcodes leave it unchanged.
- A write to r0 still updates Z from the computed result.

FSM:
- States: IDLE (reset state), RUN, HALT.
- IDLE → RUN on start; PC is set to 0.
- RUN → HALT when a HALT instruction executes; the PC holds at the HALT address.
- HALT → RUN on start; PC is set to 0. Registers, Z and the output buffer are retained.
- start is ignored while in RUN.

Stalls and handshakes:
- IN: in_ready = (state==RUN && op==8). When in_valid=1, rd is written and the PC increments. When in_valid=0, the core stalls: PC, registers and Z are unchanged.
- OUT: executes when out_valid=0, or when out_valid=1 and out_ready=1 (slot frees this cycle). On execution, out_data is loaded from rd, out_valid is set, and the PC increments. Otherwise the core stalls.
- The output buffer clears out_valid on out_valid && out_ready unless it is reloaded in the same cycle. This holds in every state, including IDLE and HALT.
- PC increment wraps from 2^PSIZE−1 to 0.

## Timing
- Reset values: paddr=0, in_ready=0, out_data=0, out_valid=0, halted=0, state=IDLE, Z=0, all registers 0.
- Reset is asynchronous and takes effect mid-instruction, mid-stall and with a pending output. Any pending output is lost.
- One instruction per clk in RUN when not stalled. Register, Z, PC and output updates take effect on the same rising edge.
- A taken branch has zero penalty: the next cycle's paddr equals the target.
- Latency from start to paddr=0 with state RUN: 1 cycle. The instruction at 0 executes in that following cycle.
- halted is registered and asserts the cycle after the HALT instruction.
- out_data stays stable while out_valid=1 and out_ready=0.
- in_ready and paddr are combinational/registered as specified, with no path from out_ready to in_ready.

## Test plan
- Reset, then start; ROM: LDI r1,5; ADDI r1,3; OUT r1; HALT → out_data=8, out_valid=1 at cycle 4, halted=1 at cycle 5.
- MULI with r1=0x40 and imm=0x40 → r1=0x20. With r1=0x80 and imm=0x80 → r1=0x80, which is the wrap case (product 0x4000 selects 0x80).
- IN with in_valid low for 3 cycles, then in_data=0x7F → PC holds 3 cycles, then r2=0x7F and PC+1.
- Two back-to-back OUTs with out_ready=0 → first loads 0x11; second stalls until out_ready=1. On that cycle out_data=0x22 and out_valid stays 1.
- Loop SUBI r1,1; BNE 0 with r1=3 → exactly 3 iterations, Z=1, falls through. JMP at address 31 to 0 and PC increment wrap at 31 are both checked.
- nreset asserted during an IN stall with out_valid=1 → all outputs return to reset values immediately. start restarts at 0; start pulsed in HALT reruns with registers retained.

Source files
------------

// File: rtl/picomips_core.sv
// picoMIPS-style single-cycle core: PC, decoder, register file, ALU with
// Q1.(N-1) fractional multiply, IDLE/RUN/HALT control and handshaked I/O.
module picomips_core #(
    parameter int N     = 8,
    parameter int NREG  = 8,
    parameter int PSIZE = 5,
    localparam int RB    = $clog2(NREG),
    localparam int ISIZE = 4 + 2*RB + N
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    output logic [PSIZE-1:0] paddr,
    input  logic [ISIZE-1:0] instr,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             halted
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SUBI = 4'h4;
    localparam logic [3:0] OP_MULI = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t            state, state_nxt;
    logic [PSIZE-1:0]  pc, pc_nxt;
    logic              z;
    logic [N-1:0]      regs [NREG];

    logic [3:0]        op;
    logic [RB-1:0]     rd, rs;
    logic signed [N-1:0] imm, rd_val, rs_val;
    logic [N-1:0]      result;
    logic              wr_en, z_en, stall, exec;

    // Q1.(N-1) multiply: keep the sign-plus-fraction window of the full product.
    function automatic logic [N-1:0] frac_mul(input logic signed [N-1:0] a,
                                              input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = a * b;
        return p[2*N-2:N-1];
    endfunction

    assign op     = instr[ISIZE-1 -: 4];
    assign rd     = instr[ISIZE-5 -: RB];
    assign rs     = instr[ISIZE-5-RB -: RB];
    assign imm    = instr[N-1:0];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];

    assign paddr    = pc;
    assign halted   = (state == S_HALT);
    assign in_ready = (state == S_RUN) && (op == OP_IN);

    assign stall = ((op == OP_IN) && !in_valid) ||
                   ((op == OP_OUT) && out_valid && !out_ready);
    assign exec  = (state == S_RUN) && !stall;

    always_comb begin
        result = rd_val;
        wr_en  = 1'b0;
        z_en   = 1'b0;
        unique case (op)
            OP_ADD:  begin result = rd_val + rs_val;       wr_en = 1'b1; z_en = 1'b1; end
            OP_ADDI: begin result = rd_val + imm;          wr_en = 1'b1; z_en = 1'b1; end
            OP_SUB:  begin result = rd_val - rs_val;       wr_en = 1'b1; z_en = 1'b1; end
            OP_SUBI: begin result = rd_val - imm;          wr_en = 1'b1; z_en = 1'b1; end
            OP_MULI: begin result = frac_mul(rd_val, imm); wr_en = 1'b1; z_en = 1'b1; end
            OP_MOV:  begin result = rs_val;                wr_en = 1'b1; end
            OP_LDI:  begin result = imm;                   wr_en = 1'b1; end
            OP_IN:   begin result = in_data;               wr_en = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = '0;
                end
            end
            S_RUN: begin
                if (op == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if (!stall) begin
                    if ((op == OP_JMP) || (op == OP_BEQ && z) || (op == OP_BNE && !z))
                        pc_nxt = imm[PSIZE-1:0];
                    else
                        pc_nxt = pc + PSIZE'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            z <= 1'b0;
        end else if (exec) begin
            if (wr_en && (rd != '0)) regs[rd] <= result;
            if (z_en) z <= (result == '0);
        end
    end

    // A reload in the same cycle as a drain keeps out_valid high.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (exec && (op == OP_OUT)) begin
            out_data  <= rd_val;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_picomips_core.sv
// Self-checking bench for picomips_core: ROM model, output scoreboard and
// one task per scenario.
module tb_picomips_core;

    localparam int N = 8;
    localparam int PSIZE = 5;
    localparam int ISIZE = 18;

    logic             clk = 1'b0;
    logic             nreset;
    logic             start;
    logic [PSIZE-1:0] paddr;
    logic [ISIZE-1:0] instr;
    logic [N-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             halted;

    logic [ISIZE-1:0] rom [32];
    logic [N-1:0]     sb [$];
    int               checks = 0;
    int               errors = 0;

    picomips_core dut (
        .clk(clk), .nreset(nreset), .start(start), .paddr(paddr), .instr(instr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted)
    );

    always #5 clk = ~clk;
    assign instr = rom[paddr];

    // Scoreboard: every accepted output must match the oldest expectation.
    always @(negedge clk) begin
        if (nreset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %h, none expected", out_data);
            end else begin
                logic [N-1:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data: got %h, expected %h", out_data, e);
                end
            end
        end
    end

    function automatic logic [ISIZE-1:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                             input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        #3;
        nreset = 1'b1;
        sb.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_halt(input string name);
        for (int i = 0; i < 200 && !halted; i++) step();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt_timeout: halted=%b, expected 1", name, halted);
        end
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d outputs missing, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #1;
        checks += 5;
        if (paddr !== 5'd0)    begin errors++; $display("FAIL rst_paddr: got %h, expected 0", paddr); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        if (out_data !== 8'h0) begin errors++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        if (halted !== 1'b0)   begin errors++; $display("FAIL rst_halted: got %b, expected 0", halted); end
        step();
        nreset = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        clear_rom();
        rom[0] = enc(4'h7, 3'd1, 3'd0, 8'd5);
        rom[1] = enc(4'h2, 3'd1, 3'd0, 8'd3);
        rom[2] = enc(4'h9, 3'd1, 3'd0, 8'd0);
        rom[3] = enc(4'hD, 3'd0, 3'd0, 8'd0);
        sb.push_back(8'd8);
        pulse_start();
        checks++;
        if (paddr !== 5'd0) begin errors++; $display("FAIL basic_pc0: got %0d, expected 0", paddr); end
        step();
        step();
        step();
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b, expected 1", out_valid); end
        if (out_data !== 8'd8)  begin errors++; $display("FAIL basic_out_data: got %h, expected 08", out_data); end
        if (halted !== 1'b0)    begin errors++; $display("FAIL basic_halted_early: got %b, expected 0", halted); end
        step();
        checks += 2;
        if (halted !== 1'b1)  begin errors++; $display("FAIL basic_halted: got %b, expected 1", halted); end
        if (paddr !== 5'd3)   begin errors++; $display("FAIL basic_halt_pc: got %0d, expected 3", paddr); end
        run_until_halt("basic");
    endtask

    task automatic test_alu();
        do_reset();
        clear_rom();
        rom[0]  = enc(4'h7, 3'd1, 3'd0, 8'h40);
        rom[1]  = enc(4'h5, 3'd1, 3'd0, 8'h40);
        rom[2]  = enc(4'h9, 3'd1, 3'd0, 8'h00);
        rom[3]  = enc(4'h7, 3'd1, 3'd0, 8'h80);
        rom[4]  = enc(4'h5, 3'd1, 3'd0, 8'h80);
        rom[5]  = enc(4'h9, 3'd1, 3'd0, 8'h00);
        rom[6]  = enc(4'h7, 3'd2, 3'd0, 8'hF0);
        rom[7]  = enc(4'h1, 3'd2, 3'd1, 8'h00);
        rom[8]  = enc(4'h9, 3'd2, 3'd0, 8'h00);
        rom[9]  = enc(4'h3, 3'd2, 3'd2, 8'h00);
        rom[10] = enc(4'hA, 3'd0, 3'd0, 8'd12);
        rom[11] = enc(4'h9, 3'd1, 3'd0, 8'h00);
        rom[12] = enc(4'h6, 3'd3, 3'd1, 8'h00);
        rom[13] = enc(4'h9, 3'd3, 3'd0, 8'h00);
        rom[14] = enc(4'h7, 3'd0, 3'd0, 8'h99);
        rom[15] = enc(4'h9, 3'd0, 3'd0, 8'h00);
        rom[16] = enc(4'hD, 3'd0, 3'd0, 8'h00);
        sb.push_back(8'h20);
        sb.push_back(8'h80);
        sb.push_back(8'h70);
        sb.push_back(8'h80);
        sb.push_back(8'h00);
        pulse_start();
        run_until_halt("alu");
    endtask

    task automatic test_in_stall();
        do_reset();
        clear_rom();
        rom[0] = enc(4'h8, 3'd2, 3'd0, 8'h00);
        rom[1] = enc(4'h9, 3'd2, 3'd0, 8'h00);
        rom[2] = enc(4'hD, 3'd0, 3'd0, 8'h00);
        in_valid = 1'b0;
        in_data  = 8'hAA;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (paddr !== 5'd0)    begin errors++; $display("FAIL in_stall_pc: got %0d, expected 0", paddr); end
            if (in_ready !== 1'b1) begin errors++; $display("FAIL in_stall_ready: got %b, expected 1", in_ready); end
            step();
        end
        in_data  = 8'h7F;
        in_valid = 1'b1;
        sb.push_back(8'h7F);
        step();
        in_valid = 1'b0;
        checks += 2;
        if (paddr !== 5'd1)    begin errors++; $display("FAIL in_taken_pc: got %0d, expected 1", paddr); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL in_taken_ready: got %b, expected 0", in_ready); end
        run_until_halt("in");
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_rom();
        rom[0] = enc(4'h7, 3'd1, 3'd0, 8'h11);
        rom[1] = enc(4'h7, 3'd2, 3'd0, 8'h22);
        rom[2] = enc(4'h9, 3'd1, 3'd0, 8'h00);
        rom[3] = enc(4'h9, 3'd2, 3'd0, 8'h00);
        rom[4] = enc(4'hD, 3'd0, 3'd0, 8'h00);
        out_ready = 1'b0;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        pulse_start();
        step();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (paddr !== 5'd3)      begin errors++; $display("FAIL b2b_stall_pc: got %0d, expected 3", paddr); end
            if (out_valid !== 1'b1)  begin errors++; $display("FAIL b2b_stall_valid: got %b, expected 1", out_valid); end
            if (out_data !== 8'h11)  begin errors++; $display("FAIL b2b_stall_data: got %h, expected 11", out_data); end
            step();
        end
        pulse_start();
        checks++;
        if (paddr !== 5'd3) begin errors++; $display("FAIL b2b_start_ignored: got %0d, expected 3", paddr); end
        out_ready = 1'b1;
        step();
        checks += 3;
        if (paddr !== 5'd4)     begin errors++; $display("FAIL b2b_pc: got %0d, expected 4", paddr); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b, expected 1", out_valid); end
        if (out_data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h, expected 22", out_data); end
        run_until_halt("b2b");
    endtask

    task automatic test_loop();
        do_reset();
        clear_rom();
        rom[0] = enc(4'h7, 3'd1, 3'd0, 8'd3);
        rom[1] = enc(4'h4, 3'd1, 3'd0, 8'd1);
        rom[2] = enc(4'h9, 3'd1, 3'd0, 8'd0);
        rom[3] = enc(4'hB, 3'd0, 3'd0, 8'd1);
        rom[4] = enc(4'hD, 3'd0, 3'd0, 8'd0);
        sb.push_back(8'd2);
        sb.push_back(8'd1);
        sb.push_back(8'd0);
        pulse_start();
        run_until_halt("loop");
        checks++;
        if (paddr !== 5'd4) begin errors++; $display("FAIL loop_exit_pc: got %0d, expected 4", paddr); end
    endtask

    task automatic run_trace(input string name, input int exp_pc[$]);
        sb.push_back(8'd1);
        sb.push_back(8'd2);
        pulse_start();
        foreach (exp_pc[i]) begin
            step();
            checks++;
            if (paddr !== exp_pc[i][PSIZE-1:0]) begin
                errors++;
                $display("FAIL %s_pc[%0d]: got %0d, expected %0d", name, i, paddr, exp_pc[i]);
            end
        end
        run_until_halt(name);
        checks++;
        if (paddr !== 5'd6) begin errors++; $display("FAIL %s_halt_pc: got %0d, expected 6", name, paddr); end
    endtask

    task automatic test_wrap();
        int seq_a[$];
        int seq_b[$];
        seq_a = '{1, 2, 3, 4, 5, 30, 31, 0, 1, 2, 3, 4, 6};
        seq_b = '{1, 2, 3, 4, 5, 31, 0, 1, 2, 3, 4, 6};
        do_reset();
        clear_rom();
        rom[0] = enc(4'h2, 3'd3, 3'd0, 8'd1);
        rom[1] = enc(4'h9, 3'd3, 3'd0, 8'd0);
        rom[2] = enc(4'h6, 3'd4, 3'd3, 8'd0);
        rom[3] = enc(4'h4, 3'd4, 3'd0, 8'd2);
        rom[4] = enc(4'hA, 3'd0, 3'd0, 8'd6);
        rom[5] = enc(4'hC, 3'd0, 3'd0, 8'd30);
        rom[6] = enc(4'hD, 3'd0, 3'd0, 8'd0);
        run_trace("wrap", seq_a);
        do_reset();
        rom[5]  = enc(4'hC, 3'd0, 3'd0, 8'd31);
        rom[31] = enc(4'hC, 3'd0, 3'd0, 8'd0);
        run_trace("jmp31", seq_b);
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_rom();
        rom[0] = enc(4'h7, 3'd1, 3'd0, 8'h33);
        rom[1] = enc(4'h9, 3'd1, 3'd0, 8'h00);
        rom[2] = enc(4'h8, 3'd2, 3'd0, 8'h00);
        rom[3] = enc(4'hD, 3'd0, 3'd0, 8'h00);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        pulse_start();
        step();
        step();
        step();
        checks += 3;
        if (paddr !== 5'd2)     begin errors++; $display("FAIL mid_pc: got %0d, expected 2", paddr); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_in_ready: got %b, expected 1", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_out_valid: got %b, expected 1", out_valid); end
        nreset = 1'b0;
        #1;
        checks += 5;
        if (paddr !== 5'd0)     begin errors++; $display("FAIL mid_rst_pc: got %0d, expected 0", paddr); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_ready: got %b, expected 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b, expected 0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL mid_rst_out_data: got %h, expected 00", out_data); end
        if (halted !== 1'b0)    begin errors++; $display("FAIL mid_rst_halted: got %b, expected 0", halted); end
        #2;
        nreset = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        step();
        checks++;
        if (paddr !== 5'd0) begin errors++; $display("FAIL mid_idle_pc: got %0d, expected 0", paddr); end
        rom[0] = enc(4'h2, 3'd1, 3'd0, 8'd1);
        rom[1] = enc(4'h9, 3'd1, 3'd0, 8'd0);
        rom[2] = enc(4'hD, 3'd0, 3'd0, 8'd0);
        sb.push_back(8'd1);
        pulse_start();
        run_until_halt("restart");
        sb.push_back(8'd2);
        pulse_start();
        checks += 2;
        if (halted !== 1'b0) begin errors++; $display("FAIL rerun_halted: got %b, expected 0", halted); end
        if (paddr !== 5'd0)  begin errors++; $display("FAIL rerun_pc: got %0d, expected 0", paddr); end
        run_until_halt("rerun");
    endtask

    initial begin
        nreset    = 1'b0;
        start     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_rom();
        test_reset();
        test_basic();
        test_alu();
        test_in_stall();
        test_back_to_back();
        test_loop();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
